// File: rtl/phv_queue_dispatch_pkg.sv
// Shared defaults and encodings for the PHV queue dispatch stage.
// Mirrors the PHV layout constants used across the Menshen pipeline.
package phv_queue_dispatch_pkg;

    localparam int PHV_LEN_DEF       = 1152;
    localparam int QUEUE_BIT_OFF_DEF = 141;
    localparam int C_NUM_QUEUES_DEF  = 4;
    localparam int CNT_WIDTH_DEF     = 32;

    typedef enum logic {
        EMPTY_DROP    = 1'b0,
        EMPTY_DEFAULT = 1'b1
    } empty_mode_e;

endpackage

// File: rtl/phv_queue_dispatch.sv
// Fans a PHV out to per-queue FIFOs, steered by its queue bitmap.
// A multicast PHV is held until every selected queue has taken its copy.
module phv_queue_dispatch
    import phv_queue_dispatch_pkg::*;
#(
    parameter int PHV_LEN        = PHV_LEN_DEF,
    parameter int C_NUM_QUEUES   = C_NUM_QUEUES_DEF,
    parameter int QUEUE_BIT_OFF  = QUEUE_BIT_OFF_DEF,
    parameter int EMPTY_MODE     = 0,
    parameter int DEFAULT_QUEUE  = 0,
    parameter int ONEHOT_REWRITE = 0,
    parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
    input  logic                            axis_clk,
    input  logic                            aresetn,
    input  logic [PHV_LEN-1:0]              phv_in,
    input  logic                            phv_in_valid,
    output logic                            phv_in_ready,
    output logic [C_NUM_QUEUES*PHV_LEN-1:0] phv_out,
    output logic [C_NUM_QUEUES-1:0]         phv_out_valid,
    input  logic [C_NUM_QUEUES-1:0]         phv_fifo_ready,
    output logic [CNT_WIDTH-1:0]            drop_cnt,
    output logic [CNT_WIDTH-1:0]            mcast_cnt
);

    localparam logic [C_NUM_QUEUES-1:0] DEFAULT_MASK = C_NUM_QUEUES'(1) << DEFAULT_QUEUE;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [PHV_LEN-1:0]      phv_r_q, phv_r_d;
    logic [C_NUM_QUEUES-1:0] pending_q, pending_d;
    logic [CNT_WIDTH-1:0]    drop_cnt_q, drop_cnt_d;
    logic [CNT_WIDTH-1:0]    mcast_cnt_q, mcast_cnt_d;
    logic [C_NUM_QUEUES-1:0] bm;
    logic                    done;
    logic                    accept;

    assign bm     = phv_in[QUEUE_BIT_OFF +: C_NUM_QUEUES];
    assign done   = ((pending_q & ~phv_fifo_ready) == '0);
    assign accept = phv_in_valid & done;

    always_comb begin
        // Retire any copy taken this cycle; when done this empties pending.
        pending_d   = pending_q & ~phv_fifo_ready;
        phv_r_d     = phv_r_q;
        drop_cnt_d  = drop_cnt_q;
        mcast_cnt_d = mcast_cnt_q;
        if (accept) begin
            if (bm != '0) begin
                phv_r_d   = phv_in;
                pending_d = bm;
                if ((bm & (bm - C_NUM_QUEUES'(1))) != '0)
                    mcast_cnt_d = sat_inc(mcast_cnt_q);
            end else if (EMPTY_MODE == int'(EMPTY_DEFAULT)) begin
                phv_r_d   = phv_in;
                pending_d = DEFAULT_MASK;
            end else begin
                pending_d  = '0;
                drop_cnt_d = sat_inc(drop_cnt_q);
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            phv_r_q     <= '0;
            pending_q   <= '0;
            drop_cnt_q  <= '0;
            mcast_cnt_q <= '0;
        end else begin
            phv_r_q     <= phv_r_d;
            pending_q   <= pending_d;
            drop_cnt_q  <= drop_cnt_d;
            mcast_cnt_q <= mcast_cnt_d;
        end
    end

    for (genvar i = 0; i < C_NUM_QUEUES; i++) begin : g_queue
        logic [PHV_LEN-1:0] copy;
        always_comb begin
            copy = phv_r_q;
            if (ONEHOT_REWRITE != 0)
                copy[QUEUE_BIT_OFF +: C_NUM_QUEUES] = C_NUM_QUEUES'(1) << i;
        end
        assign phv_out[i*PHV_LEN +: PHV_LEN] = copy;
    end

    assign phv_in_ready  = done;
    assign phv_out_valid = pending_q;
    assign drop_cnt      = drop_cnt_q;
    assign mcast_cnt     = mcast_cnt_q;

endmodule

// File: tb/tb_phv_queue_dispatch.sv
// Randomized bench: two dispatch instances (drop / default-queue with one-hot rewrite)
// checked against a per-queue delivery scoreboard.
module tb_phv_queue_dispatch;

    localparam int PL   = 1152;
    localparam int NQ   = 4;
    localparam int QO   = 141;
    localparam int CW_A = 32;
    localparam int CW_B = 3;
    localparam int NCYC = 4000;

    logic            axis_clk = 1'b0;
    logic            aresetn;
    logic [PL-1:0]   phv_in;
    logic            phv_in_valid;
    logic [NQ-1:0]   phv_fifo_ready;

    logic            a_rdy, b_rdy;
    logic [NQ*PL-1:0] a_out, b_out;
    logic [NQ-1:0]   a_vld, b_vld;
    logic [CW_A-1:0] a_drop, a_mc;
    logic [CW_B-1:0] b_drop, b_mc;

    always #5 axis_clk = ~axis_clk;

    phv_queue_dispatch #(
        .PHV_LEN(PL), .C_NUM_QUEUES(NQ), .QUEUE_BIT_OFF(QO), .EMPTY_MODE(0),
        .DEFAULT_QUEUE(0), .ONEHOT_REWRITE(0), .CNT_WIDTH(CW_A)
    ) dut_a (
        .axis_clk(axis_clk), .aresetn(aresetn), .phv_in(phv_in), .phv_in_valid(phv_in_valid),
        .phv_in_ready(a_rdy), .phv_out(a_out), .phv_out_valid(a_vld),
        .phv_fifo_ready(phv_fifo_ready), .drop_cnt(a_drop), .mcast_cnt(a_mc)
    );

    phv_queue_dispatch #(
        .PHV_LEN(PL), .C_NUM_QUEUES(NQ), .QUEUE_BIT_OFF(QO), .EMPTY_MODE(1),
        .DEFAULT_QUEUE(2), .ONEHOT_REWRITE(1), .CNT_WIDTH(CW_B)
    ) dut_b (
        .axis_clk(axis_clk), .aresetn(aresetn), .phv_in(phv_in), .phv_in_valid(phv_in_valid),
        .phv_in_ready(b_rdy), .phv_out(b_out), .phv_out_valid(b_vld),
        .phv_fifo_ready(phv_fifo_ready), .drop_cnt(b_drop), .mcast_cnt(b_mc)
    );

    // Scoreboard: per instance, per queue, the PHVs still owed to that queue.
    logic [PL-1:0] exp_q [2][NQ][$];
    longint        drop_m [2];
    longint        mc_m   [2];
    longint        cap    [2] = '{64'hFFFF_FFFF, 64'd7};

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [PL-1:0] obs, input logic [PL-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_done(input int k);
        for (int i = 0; i < NQ; i++)
            if (exp_q[k][i].size() != 0 && !phv_fifo_ready[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [NQ-1:0] model_valid(input int k);
        logic [NQ-1:0] v = '0;
        for (int i = 0; i < NQ; i++) v[i] = (exp_q[k][i].size() != 0);
        return v;
    endfunction

    task automatic model_step(input int k);
        bit            d;
        logic [NQ-1:0] bm;
        if (!aresetn) begin
            for (int i = 0; i < NQ; i++) exp_q[k][i].delete();
            drop_m[k] = 0;
            mc_m[k]   = 0;
            return;
        end
        d = model_done(k);
        for (int i = 0; i < NQ; i++)
            if (exp_q[k][i].size() != 0 && phv_fifo_ready[i]) void'(exp_q[k][i].pop_front());
        if (phv_in_valid && d) begin
            bm = phv_in[QO +: NQ];
            if (bm != '0) begin
                for (int i = 0; i < NQ; i++) if (bm[i]) exp_q[k][i].push_back(phv_in);
                if ($countones(bm) > 1 && mc_m[k] < cap[k]) mc_m[k]++;
            end else if (k == 0) begin
                if (drop_m[k] < cap[k]) drop_m[k]++;
            end else begin
                exp_q[k][2].push_back(phv_in);
            end
        end
    endtask

    task automatic check_outputs();
        logic [PL-1:0] e;
        check_val("a_valid", PL'(a_vld), PL'(model_valid(0)));
        check_val("b_valid", PL'(b_vld), PL'(model_valid(1)));
        check_val("a_drop_cnt", PL'(a_drop), PL'(drop_m[0]));
        check_val("a_mcast_cnt", PL'(a_mc), PL'(mc_m[0]));
        check_val("b_drop_cnt", PL'(b_drop), PL'(drop_m[1]));
        check_val("b_mcast_cnt", PL'(b_mc), PL'(mc_m[1]));
        for (int i = 0; i < NQ; i++) begin
            if (exp_q[0][i].size() != 0)
                check_val($sformatf("a_phv_q%0d", i), a_out[i*PL +: PL], exp_q[0][i][0]);
            if (exp_q[1][i].size() != 0) begin
                e = exp_q[1][i][0];
                e[QO +: NQ] = NQ'(1) << i;
                check_val($sformatf("b_phv_q%0d", i), b_out[i*PL +: PL], e);
            end
        end
    endtask

    function automatic logic [PL-1:0] rand_phv();
        logic [PL-1:0] p;
        logic [NQ-1:0] bm;
        for (int w = 0; w < PL / 32; w++) p[w*32 +: 32] = $urandom;
        case ($urandom_range(9))
            0, 1:    bm = '0;
            2, 3, 4: bm = NQ'(1) << $urandom_range(NQ - 1);
            default: bm = NQ'($urandom);
        endcase
        p[QO +: NQ] = bm;
        return p;
    endfunction

    initial begin
        aresetn        = 1'b0;
        phv_in         = '0;
        phv_in_valid   = 1'b0;
        phv_fifo_ready = '0;
        for (int k = 0; k < 2; k++) begin
            drop_m[k] = 0;
            mc_m[k]   = 0;
        end
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge axis_clk);
            check_outputs();
            aresetn      = !(cyc < 3 || $urandom_range(99) < 2);
            phv_in_valid = ($urandom_range(9) < 8);
            phv_in       = rand_phv();
            if ((cyc / 200) % 2 == 1)
                phv_fifo_ready = '1;
            else
                for (int i = 0; i < NQ; i++) phv_fifo_ready[i] = ($urandom_range(9) < 6);
            #1;
            check_val("a_in_ready", PL'(a_rdy), PL'(model_done(0)));
            check_val("b_in_ready", PL'(b_rdy), PL'(model_done(1)));
            model_step(0);
            model_step(1);
            @(posedge axis_clk);
        end
        @(negedge axis_clk);
        check_outputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
